// File: rtl/fpu_ss_pkg.sv
// Shared types and constants for the FPU subsystem core arbiter.
//   arb_lock_state_e : lock FSM states of the round-robin arbiter
//   CORE_ID_W        : width of the core-ID fields at the subsystem boundary
//   CREDIT_W         : width of a per-core outstanding-instruction counter
package fpu_ss_pkg;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } arb_lock_state_e;

    localparam int unsigned CORE_ID_W = 32;
    localparam int unsigned CREDIT_W  = 4;

endpackage

// File: rtl/fpu_ss_rr_arbiter.sv
// Round-robin arbiter with grant locking.
// A request that is presented but not accepted locks the grant onto that
// requester until the handshake completes, so the winner cannot change
// while the subsystem is stalling.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   req_i         : per-requester eligible request
//   ready_i       : downstream accept
//   valid_o       : a grant is present
//   gnt_o         : one-hot grant
//   gnt_id_o      : granted index (0 when no grant)
module fpu_ss_rr_arbiter
    import fpu_ss_pkg::*;
#(
    parameter int unsigned NB_CORES = 8,
    localparam int unsigned IdxW    = $clog2(NB_CORES)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NB_CORES-1:0] req_i,
    input  logic                ready_i,
    output logic                valid_o,
    output logic [NB_CORES-1:0] gnt_o,
    output logic [IdxW-1:0]     gnt_id_o
);

    arb_lock_state_e state_q, state_d;
    logic [IdxW-1:0] ptr_q, ptr_d;
    logic [IdxW-1:0] lock_id_q, lock_id_d;
    logic [IdxW-1:0] win_id;
    logic            win_found;
    logic [IdxW:0]   cand;

    // First requester at or after ptr_q, with wrap-around.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int unsigned i = 0; i < NB_CORES; i++) begin
            cand = {1'b0, ptr_q} + (IdxW + 1)'(i);
            if (cand >= (IdxW + 1)'(NB_CORES)) begin
                cand = cand - (IdxW + 1)'(NB_CORES);
            end
            if (!win_found && req_i[cand[IdxW-1:0]]) begin
                win_found = 1'b1;
                win_id    = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        ptr_d     = ptr_q;
        valid_o   = 1'b0;
        gnt_id_o  = '0;
        unique case (state_q)
            UNLOCKED: begin
                valid_o  = win_found;
                gnt_id_o = win_id;
                if (win_found && !ready_i) begin
                    state_d   = LOCKED;
                    lock_id_d = win_id;
                end
            end
            LOCKED: begin
                // Requester is obliged to hold valid until accepted.
                valid_o  = 1'b1;
                gnt_id_o = lock_id_q;
                if (ready_i) begin
                    state_d = UNLOCKED;
                end
            end
            default: ;
        endcase
        if (valid_o && ready_i) begin
            ptr_d = (gnt_id_o == IdxW'(NB_CORES - 1)) ? '0 : gnt_id_o + 1'b1;
        end
    end

    assign gnt_o = valid_o ? (NB_CORES'(1) << gnt_id_o) : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= UNLOCKED;
            lock_id_q <= '0;
            ptr_q     <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
            ptr_q     <= ptr_d;
        end
    end

endmodule

// File: rtl/fpu_ss_core_arbiter.sv
// Shares one FPU subsystem between NB_CORES cores: round-robin issue
// arbitration with grant locking, result routing by core ID, outstanding
// instruction tracking for idle_o.
// Configuration macro FPU_SS_ARB_CREDIT_EN: when defined, per-core credit
// counters limit each core to MAX_OUTSTANDING issued-but-unreturned
// instructions; otherwise a single saturating global counter only feeds idle_o.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   core_issue_valid_i/_ready_o : per-core issue handshake
//   ss_issue_valid_o/_ready_i   : issue handshake to the subsystem
//   ss_core_id_o         : granted core index, zero-extended
//   ss_result_valid_i/_ready_o, ss_result_core_id_i : result from subsystem
//   core_result_valid_o/_ready_i : per-core result handshake
//   idle_o               : nothing outstanding
//   err_o                : sticky, a result carried an out-of-range core ID
module fpu_ss_core_arbiter
    import fpu_ss_pkg::*;
#(
    parameter int unsigned NB_CORES        = 8,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NB_CORES-1:0]  core_issue_valid_i,
    output logic [NB_CORES-1:0]  core_issue_ready_o,
    output logic                 ss_issue_valid_o,
    input  logic                 ss_issue_ready_i,
    output logic [CORE_ID_W-1:0] ss_core_id_o,
    input  logic                 ss_result_valid_i,
    input  logic [CORE_ID_W-1:0] ss_result_core_id_i,
    output logic                 ss_result_ready_o,
    output logic [NB_CORES-1:0]  core_result_valid_o,
    input  logic [NB_CORES-1:0]  core_result_ready_i,
    output logic                 idle_o,
    output logic                 err_o
);

    localparam int unsigned IdxW = $clog2(NB_CORES);

    logic [NB_CORES-1:0] eligible;
    logic [NB_CORES-1:0] gnt;
    logic [IdxW-1:0]     gnt_id;
    logic                issue_hs;
    logic                res_in_range;
    logic [IdxW-1:0]     res_id;
    logic [NB_CORES-1:0] res_sel;
    logic                res_hs;
    logic                err_q;

    // ---------------- issue path ----------------
    fpu_ss_rr_arbiter #(
        .NB_CORES (NB_CORES)
    ) u_rr_arbiter (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (eligible),
        .ready_i  (ss_issue_ready_i),
        .valid_o  (ss_issue_valid_o),
        .gnt_o    (gnt),
        .gnt_id_o (gnt_id)
    );

    assign issue_hs           = ss_issue_valid_o & ss_issue_ready_i;
    assign core_issue_ready_o = gnt & {NB_CORES{ss_issue_ready_i}};
    assign ss_core_id_o       = ss_issue_valid_o ? CORE_ID_W'(gnt_id) : '0;

    // ---------------- result path ----------------
    assign res_in_range        = ss_result_core_id_i < CORE_ID_W'(NB_CORES);
    assign res_id              = ss_result_core_id_i[IdxW-1:0];
    assign res_sel             = res_in_range ? (NB_CORES'(1) << res_id) : '0;
    assign core_result_valid_o = ss_result_valid_i ? res_sel : '0;
    // Out-of-range results are swallowed so the subsystem never stalls on them.
    assign ss_result_ready_o   = res_in_range ? core_result_ready_i[res_id] : 1'b1;
    // Only results actually delivered to a core return credit.
    assign res_hs              = ss_result_valid_i & ss_result_ready_o & res_in_range;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_q <= 1'b0;
        end else if (ss_result_valid_i && !res_in_range) begin
            err_q <= 1'b1;
        end
    end

    assign err_o = err_q;

    // ---------------- outstanding tracking ----------------
`ifdef FPU_SS_ARB_CREDIT_EN
    logic [CREDIT_W-1:0] cnt_q [NB_CORES];
    logic [CREDIT_W-1:0] cnt_d [NB_CORES];
    logic [NB_CORES-1:0] credit_ok;
    logic [NB_CORES-1:0] cnt_zero;

    always_comb begin
        for (int unsigned k = 0; k < NB_CORES; k++) begin
            cnt_d[k]     = cnt_q[k];
            credit_ok[k] = cnt_q[k] < CREDIT_W'(MAX_OUTSTANDING);
            cnt_zero[k]  = cnt_q[k] == '0;
            // core_issue_ready_o[k] implies a grant, i.e. an issue handshake.
            if (core_issue_ready_o[k] && !(res_hs && res_sel[k])) begin
                cnt_d[k] = cnt_q[k] + 1'b1;
            end else if (!core_issue_ready_o[k] && res_hs && res_sel[k]) begin
                cnt_d[k] = cnt_q[k] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned k = 0; k < NB_CORES; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < NB_CORES; k++) begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    assign eligible = core_issue_valid_i & credit_ok;
    assign idle_o   = &cnt_zero;
`else
    localparam int unsigned     GlobW   = $clog2(NB_CORES * MAX_OUTSTANDING + 1);
    localparam logic [GlobW-1:0] GlobMax = GlobW'(NB_CORES * MAX_OUTSTANDING);

    logic [GlobW-1:0] glob_q, glob_d;

    always_comb begin
        glob_d = glob_q;
        if (issue_hs && !res_hs && glob_q != GlobMax) begin
            glob_d = glob_q + 1'b1;
        end else if (!issue_hs && res_hs && glob_q != '0) begin
            glob_d = glob_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            glob_q <= '0;
        end else begin
            glob_q <= glob_d;
        end
    end

    assign eligible = core_issue_valid_i;
    assign idle_o   = glob_q == '0;
`endif

endmodule

// File: tb/tb_fpu_ss_core_arbiter.sv
// Directed bench for fpu_ss_core_arbiter (NB_CORES = 8, MAX_OUTSTANDING = 4).
// Expected grants are queued when requests are driven and popped on each
// observed issue handshake; a per-core outstanding model predicts idle_o.
module tb_fpu_ss_core_arbiter;

    localparam int unsigned NB_CORES        = 8;
    localparam int unsigned MAX_OUTSTANDING = 4;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic [NB_CORES-1:0] core_issue_valid_i;
    logic [NB_CORES-1:0] core_issue_ready_o;
    logic                ss_issue_valid_o;
    logic                ss_issue_ready_i;
    logic [31:0]         ss_core_id_o;
    logic                ss_result_valid_i;
    logic [31:0]         ss_result_core_id_i;
    logic                ss_result_ready_o;
    logic [NB_CORES-1:0] core_result_valid_o;
    logic [NB_CORES-1:0] core_result_ready_i;
    logic                idle_o;
    logic                err_o;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];
    int outst[NB_CORES];
    int total = 0;

    fpu_ss_core_arbiter #(
        .NB_CORES        (NB_CORES),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .core_issue_valid_i  (core_issue_valid_i),
        .core_issue_ready_o  (core_issue_ready_o),
        .ss_issue_valid_o    (ss_issue_valid_o),
        .ss_issue_ready_i    (ss_issue_ready_i),
        .ss_core_id_o        (ss_core_id_o),
        .ss_result_valid_i   (ss_result_valid_i),
        .ss_result_core_id_i (ss_result_core_id_i),
        .ss_result_ready_o   (ss_result_ready_o),
        .core_result_valid_o (core_result_valid_o),
        .core_result_ready_i (core_result_ready_i),
        .idle_o              (idle_o),
        .err_o               (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called mid-cycle: if a handshake is on the bus, it must match the queue head.
    task automatic obs_issue(input string tag);
        int e;
        if (ss_issue_valid_o && ss_issue_ready_i) begin
            if (exp_q.size() == 0) begin
                chk({tag, "_unexpected_hs"}, 32'(ss_issue_valid_o), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk({tag, "_id"}, ss_core_id_o, 32'(e));
                chk({tag, "_rdy"}, 32'(core_issue_ready_o), 32'd1 << e);
                outst[e]++;
                total++;
            end
        end
    endtask

    task automatic run_issue(input string tag, input int budget);
        int cyc = 0;
        while (exp_q.size() != 0 && cyc < budget) begin
            #1;
            obs_issue(tag);
            @(negedge clk_i);
            cyc++;
        end
        if (exp_q.size() != 0) begin
            chk({tag, "_timeout_left"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    task automatic ret(input int k);
        ss_result_valid_i   = 1'b1;
        ss_result_core_id_i = 32'(k);
        core_result_ready_i = NB_CORES'(1) << k;
        #1;
        chk("ret_core_valid", 32'(core_result_valid_o), 32'd1 << k);
        chk("ret_ss_ready", 32'(ss_result_ready_o), 32'd1);
        @(negedge clk_i);
        outst[k]--;
        total--;
        ss_result_valid_i   = 1'b0;
        ss_result_core_id_i = '0;
        core_result_ready_i = '0;
        #1;
        chk("ret_idle", 32'(idle_o), 32'(total == 0));
    endtask

    initial begin
        rst_ni              = 1'b0;
        core_issue_valid_i  = '0;
        ss_issue_ready_i    = 1'b0;
        ss_result_valid_i   = 1'b0;
        ss_result_core_id_i = '0;
        core_result_ready_i = '0;
        for (int k = 0; k < NB_CORES; k++) outst[k] = 0;

        // Reset state
        #1;
        chk("rst_ss_valid", 32'(ss_issue_valid_o), 32'd0);
        chk("rst_core_ready", 32'(core_issue_ready_o), 32'd0);
        chk("rst_core_id", ss_core_id_o, 32'd0);
        chk("rst_res_ready", 32'(ss_result_ready_o), 32'd0);
        chk("rst_res_valid", 32'(core_result_valid_o), 32'd0);
        chk("rst_idle", 32'(idle_o), 32'd1);
        chk("rst_err", 32'(err_o), 32'd0);
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Round robin across cores 0, 3, 5, one grant per cycle
        core_issue_valid_i = 8'b0010_1001;
        ss_issue_ready_i   = 1'b1;
        exp_q = '{0, 3, 5, 0, 3, 5};
        run_issue("rr", 6);
        core_issue_valid_i = '0;
        ss_issue_ready_i   = 1'b0;
        #1;
        chk("rr_idle", 32'(idle_o), 32'd0);
        for (int k = 0; k < NB_CORES; k++) begin
            while (outst[k] > 0) ret(k);
        end

        // Lock: core 2 stalled three cycles, core 1 joins but must wait
        core_issue_valid_i = 8'b0000_0100;
        #1;
        chk("lock_c0_valid", 32'(ss_issue_valid_o), 32'd1);
        chk("lock_c0_id", ss_core_id_o, 32'd2);
        chk("lock_c0_rdy", 32'(core_issue_ready_o), 32'd0);
        @(negedge clk_i);
        core_issue_valid_i = 8'b0000_0110;
        #1;
        chk("lock_c1_id", ss_core_id_o, 32'd2);
        chk("lock_c1_rdy", 32'(core_issue_ready_o), 32'd0);
        @(negedge clk_i);
        #1;
        chk("lock_c2_id", ss_core_id_o, 32'd2);
        @(negedge clk_i);
        ss_issue_ready_i = 1'b1;
        exp_q.push_back(2);
        run_issue("lock_hs", 1);
        core_issue_valid_i = 8'b0000_0010;
        exp_q.push_back(1);
        run_issue("lock_next", 1);
        core_issue_valid_i = '0;
        ss_issue_ready_i   = 1'b0;
        ret(2);
        ret(1);

        // Core 6 issues twice; first result stalls two cycles
        core_issue_valid_i = 8'b0100_0000;
        ss_issue_ready_i   = 1'b1;
        exp_q = '{6, 6};
        run_issue("c6", 2);
        core_issue_valid_i  = '0;
        ss_issue_ready_i    = 1'b0;
        ss_result_valid_i   = 1'b1;
        ss_result_core_id_i = 32'd6;
        core_result_ready_i = '0;
        for (int c = 0; c < 2; c++) begin
            #1;
            chk("stall_valid", 32'(core_result_valid_o), 32'h40);
            chk("stall_ready", 32'(ss_result_ready_o), 32'd0);
            @(negedge clk_i);
        end
        core_result_ready_i = 8'b0100_0000;
        #1;
        chk("stall_release", 32'(ss_result_ready_o), 32'd1);
        @(negedge clk_i);
        outst[6]--;
        total--;
        ss_result_valid_i = 1'b0;
        core_result_ready_i = '0;
        #1;
        chk("stall_idle", 32'(idle_o), 32'd0);

        // Out-of-range result ID
        ss_result_valid_i   = 1'b1;
        ss_result_core_id_i = 32'd9;
        core_result_ready_i = '1;
        #1;
        chk("oor_valid", 32'(core_result_valid_o), 32'd0);
        chk("oor_ready", 32'(ss_result_ready_o), 32'd1);
        chk("oor_err_before", 32'(err_o), 32'd0);
        @(negedge clk_i);
        ss_result_valid_i   = 1'b0;
        ss_result_core_id_i = '0;
        core_result_ready_i = '0;
        #1;
        chk("oor_err_set", 32'(err_o), 32'd1);
        chk("oor_idle", 32'(idle_o), 32'd0);
        repeat (3) @(negedge clk_i);
        #1;
        chk("oor_err_sticky", 32'(err_o), 32'd1);

        // Same-cycle issue and result for core 1 with two outstanding
        core_issue_valid_i = 8'b0000_0010;
        ss_issue_ready_i   = 1'b1;
        exp_q = '{1, 1};
        run_issue("c1", 2);
        ss_result_valid_i   = 1'b1;
        ss_result_core_id_i = 32'd1;
        core_result_ready_i = 8'b0000_0010;
        exp_q.push_back(1);
        #1;
        obs_issue("same");
        chk("same_res_valid", 32'(core_result_valid_o), 32'd2);
        chk("same_res_ready", 32'(ss_result_ready_o), 32'd1);
        @(negedge clk_i);
        outst[1]--;
        total--;
        core_issue_valid_i  = '0;
        ss_issue_ready_i    = 1'b0;
        ss_result_valid_i   = 1'b0;
        ss_result_core_id_i = '0;
        core_result_ready_i = '0;
        chk("same_queue_left", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        #1;
        chk("same_idle", 32'(idle_o), 32'd0);
        ret(1);
        ret(1);
        ret(6);

`ifdef FPU_SS_ARB_CREDIT_EN
        // Credit limit on core 4; returned credit usable only next cycle
        core_issue_valid_i = 8'b0001_0000;
        ss_issue_ready_i   = 1'b1;
        exp_q = '{4, 4, 4, 4};
        run_issue("cred", 4);
        #1;
        chk("cred_block_rdy", 32'(core_issue_ready_o), 32'd0);
        chk("cred_block_valid", 32'(ss_issue_valid_o), 32'd0);
        @(negedge clk_i);
        ss_result_valid_i   = 1'b1;
        ss_result_core_id_i = 32'd4;
        core_result_ready_i = 8'b0001_0000;
        #1;
        chk("cred_same_cycle_rdy", 32'(core_issue_ready_o), 32'd0);
        @(negedge clk_i);
        outst[4]--;
        total--;
        ss_result_valid_i   = 1'b0;
        ss_result_core_id_i = '0;
        core_result_ready_i = '0;
        exp_q.push_back(4);
        run_issue("cred_fifth", 1);
`else
        // Without credits core 4 may keep issuing past MAX_OUTSTANDING
        core_issue_valid_i = 8'b0001_0000;
        ss_issue_ready_i   = 1'b1;
        exp_q = '{4, 4, 4, 4, 4};
        run_issue("nocred", 5);
`endif
        core_issue_valid_i = '0;
        ss_issue_ready_i   = 1'b0;
        while (outst[4] > 0) ret(4);

        // Reset with work outstanding clears everything at once
        core_issue_valid_i = 8'b0000_0001;
        ss_issue_ready_i   = 1'b1;
        exp_q.push_back(0);
        run_issue("pre_rst", 1);
        core_issue_valid_i = '0;
        ss_issue_ready_i   = 1'b0;
        #1;
        chk("pre_rst_idle", 32'(idle_o), 32'd0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("async_rst_idle", 32'(idle_o), 32'd1);
        chk("async_rst_err", 32'(err_o), 32'd0);
        chk("async_rst_valid", 32'(ss_issue_valid_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
